// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for the FFT frame capture controller: FSM state
// encodings, default frame/group geometry and counter width helpers.
package fft_frame_ctrl_pkg;

  // Default frame geometry: samples per frame and samples per packer group.
  localparam int NPT_DEF = 32;
  localparam int GRP_DEF = 4;

  // Controller state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ARM      = 3'd1;
  localparam state_t ST_FILL     = 3'd2;
  localparam state_t ST_WAIT_OUT = 3'd3;
  localparam state_t ST_HOLD     = 3'd4;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the group index within a frame.
  function automatic int grp_idx_width(input int npt, input int grp);
    return cnt_width(npt / grp);
  endfunction

endpackage

// File: rtl/fft_grp_cnt.sv
// Sample-in-group and group-in-frame counters for the frame controller.
// Both counters wrap explicitly, so non-power-of-two geometries also work.
module fft_grp_cnt
  import fft_frame_ctrl_pkg::*;
#(
  parameter int NPT = NPT_DEF,
  parameter int GRP = GRP_DEF,
  localparam int SW = cnt_width(GRP),
  localparam int IW = grp_idx_width(NPT, GRP)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          smp_inc,
  input  logic          smp_clr,
  input  logic          grp_inc,
  output logic          smp_last,
  output logic          grp_last,
  output logic [IW-1:0] grp_idx
);

  localparam logic [SW-1:0] SMP_MAX = SW'(GRP - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NPT / GRP - 1);

  logic [SW-1:0] smp_cnt_reg;
  logic [IW-1:0] grp_idx_reg;

  assign smp_last = (smp_cnt_reg == SMP_MAX);
  assign grp_last = (grp_idx_reg == IDX_MAX);
  assign grp_idx  = grp_idx_reg;

  // Sample position inside the current group; an aborted group restarts at 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_cnt_reg <= '0;
    end else if (smp_clr) begin
      smp_cnt_reg <= '0;
    end else if (smp_inc) begin
      smp_cnt_reg <= smp_last ? '0 : smp_cnt_reg + SW'(1);
    end
  end

  // Group index inside the frame; only advances on a completed handshake.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      grp_idx_reg <= '0;
    end else if (grp_inc) begin
      grp_idx_reg <= grp_last ? '0 : grp_idx_reg + IW'(1);
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame capture controller: gathers contiguous sample groups through a
// serial-to-parallel packer and hands each packed group to the FFT core.
// Optional feature: define FFT_FRAME_CTRL_STAT_EN to build the 8-bit
// completed-frame counter on FRM_CNT; otherwise FRM_CNT is tied to zero.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int NPT = NPT_DEF,
  parameter int GRP = GRP_DEF,
  localparam int IW = grp_idx_width(NPT, GRP)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENA,
  input  logic          IN_VLD,
  output logic          IN_RDY,
  output logic          S2P_START,
  input  logic          S2P_RDY,
  output logic          GRP_VLD,
  input  logic          GRP_RDY,
  output logic [IW-1:0] GRP_IDX,
  output logic          FRM_SOF,
  output logic          FRM_EOF,
  output logic          BUSY,
  output logic          ERR,
  output logic [7:0]    FRM_CNT
);

  state_t        state_reg;
  state_t        state_next;
  logic          wait_reg;
  logic          err_reg;
  logic          ena_reg;
  logic          smp_inc;
  logic          smp_clr;
  logic          grp_inc;
  logic          frm_done;
  logic          err_set;
  logic          smp_last;
  logic          grp_last;
  logic [IW-1:0] grp_idx;

  fft_grp_cnt #(
    .NPT (NPT),
    .GRP (GRP)
  ) u_grp_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .smp_inc  (smp_inc),
    .smp_clr  (smp_clr),
    .grp_inc  (grp_inc),
    .smp_last (smp_last),
    .grp_last (grp_last),
    .grp_idx  (grp_idx)
  );

  // Next-state and counter control; a stray packer pulse is flagged anywhere but WAIT_OUT.
  always_comb begin
    state_next = state_reg;
    smp_inc    = 1'b0;
    smp_clr    = 1'b0;
    grp_inc    = 1'b0;
    frm_done   = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ENA) state_next = ST_ARM;
      end
      ST_ARM: begin
        if (IN_VLD) begin
          smp_inc    = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (IN_VLD) begin
          smp_inc = 1'b1;
          if (smp_last) state_next = ST_WAIT_OUT;
        end else begin
          // A gap inside a group breaks packer alignment: drop and retry the group.
          smp_clr    = 1'b1;
          err_set    = 1'b1;
          state_next = ST_ARM;
        end
      end
      ST_WAIT_OUT: begin
        if (S2P_RDY) begin
          state_next = ST_HOLD;
        end else if (wait_reg) begin
          err_set    = 1'b1;
          state_next = ST_ARM;
        end
      end
      ST_HOLD: begin
        if (GRP_RDY) begin
          grp_inc = 1'b1;
          if (grp_last) begin
            frm_done   = 1'b1;
            state_next = ENA ? ST_ARM : ST_IDLE;
          end else begin
            state_next = ST_ARM;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (S2P_RDY && (state_reg != ST_WAIT_OUT)) err_set = 1'b1;
  end

  // State register, packer-wait timer and ENA history for edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      wait_reg  <= 1'b0;
      ena_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= (state_reg == ST_WAIT_OUT) && (state_next == ST_WAIT_OUT);
      ena_reg   <= ENA;
    end
  end

  // Sticky error; a new error in the same cycle as the clearing edge wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end else if ((state_reg == ST_IDLE) && ENA && !ena_reg) begin
      err_reg <= 1'b0;
    end
  end

`ifdef FFT_FRAME_CTRL_STAT_EN
  logic [7:0] frm_cnt_reg;

  // Completed-frame statistics counter, wraps naturally at 8 bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frm_cnt_reg <= 8'd0;
    end else if (frm_done) begin
      frm_cnt_reg <= frm_cnt_reg + 8'd1;
    end
  end

  assign FRM_CNT = frm_cnt_reg;
`else
  assign FRM_CNT = 8'd0;
`endif

  // The packer counts only while S2P_START is low: during FILL and on the
  // cycle that ARM accepts the first sample of a group.
  assign IN_RDY    = (state_reg == ST_ARM) || (state_reg == ST_FILL);
  assign S2P_START = !((state_reg == ST_FILL) || ((state_reg == ST_ARM) && IN_VLD));
  assign GRP_VLD   = (state_reg == ST_HOLD);
  assign GRP_IDX   = grp_idx;
  assign FRM_SOF   = (state_reg == ST_ARM) && IN_VLD && (grp_idx == '0);
  assign FRM_EOF   = frm_done;
  assign BUSY      = (state_reg != ST_IDLE);
  assign ERR       = err_reg;

endmodule
